// File: rtl/game_pkg.sv
// Shared types and screen geometry for the game-plane movement scheduler.
package game_pkg;

  typedef enum logic [1:0] {
    MODE_FROZEN = 2'b00,
    MODE_SHARED = 2'b01,
    MODE_ACCEL  = 2'b10,
    MODE_BTN    = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_STEP_H,
    S_STEP_V,
    S_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_DEC,
    DIR_INC
  } dir_t;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

endpackage

// File: rtl/game_move_sched_axis_step.sv
// Combinational single-axis step, zero latency; saturates at 0/limit, or wraps to the
// opposite edge when GAME_MOVE_WRAP_EN is defined.
module axis_step
  import game_pkg::*;
#(
  parameter int SPEED = 1
) (
  input  logic [9:0] i_coord,
  input  dir_t       i_dir,
  input  logic [9:0] i_limit,
  output logic [9:0] o_coord
);

  logic [10:0] w_inc;
  logic [9:0]  w_dec;
  logic        w_under;
  logic        w_over;

  // 11-bit sum so an increment past the limit is never hidden by a 10-bit wrap
  assign w_inc   = {1'b0, i_coord} + 11'(SPEED);
  assign w_dec   = i_coord - 10'(SPEED);
  assign w_under = i_coord < 10'(SPEED);
  assign w_over  = w_inc > {1'b0, i_limit};

  always_comb begin
    o_coord = i_coord;
    case (i_dir)
`ifdef GAME_MOVE_WRAP_EN
      DIR_DEC: o_coord = w_under ? i_limit : w_dec;
      DIR_INC: o_coord = w_over ? 10'd0 : w_inc[9:0];
`else
      DIR_DEC: o_coord = w_under ? 10'd0 : w_dec;
      DIR_INC: o_coord = w_over ? i_limit : w_inc[9:0];
`endif
      default: o_coord = i_coord;
    endcase
  end

endmodule

// File: rtl/game_move_sched.sv
// Per-frame object mover: action tick at t -> obj_h at t+3, obj_v/move_done at t+4; ticks while
// busy are dropped and flagged on sticky overrun (no backpressure). Edge wrap via GAME_MOVE_WRAP_EN.
module game_move_sched
  import game_pkg::*;
#(
  parameter int OBJ_W             = 8,
  parameter int OBJ_H             = 20,
  parameter int FRAMES_PER_ACTION = 2,
  parameter int SPEED             = 1,
  parameter int ACCEL_DEADZONE    = 2
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hold,
  input  logic [1:0] mode,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  output logic [9:0] obj_h,
  output logic [9:0] obj_v,
  output logic [1:0] grant,
  output logic       busy,
  output logic       move_done,
  output logic       overrun
);

  localparam int              DW       = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(FRAMES_PER_ACTION - 1);
  localparam logic [9:0]      H_MAX    = 10'(SCREEN_W - 1 - OBJ_W);
  localparam logic [9:0]      V_MAX    = 10'(SCREEN_H - 1 - OBJ_H);
  localparam logic [9:0]      H_RST    = 10'(SCREEN_W / 2 - 1);
  localparam logic [9:0]      V_RST    = 10'(SCREEN_H / 2 - 1);
  localparam logic signed [8:0] DZ_POS = 9'(ACCEL_DEADZONE);
  localparam logic signed [8:0] DZ_NEG = 9'(-ACCEL_DEADZONE);

  sched_state_t r_state, w_state_nxt;
  logic [DW-1:0] r_div;
  logic [3:0]    r_btn;  // {u, d, l, r}
  logic [7:0]    r_ax, r_ay;
  mode_t         r_mode;
  logic [1:0]    r_grant, r_rr_last, w_gnt;
  logic [9:0]    r_h, r_v, w_h_next, w_v_next;
  logic          r_move_done, r_overrun;
  logic          w_action, w_btn_ok, w_acc_ok, w_req_b, w_req_a, w_acc_any;
  logic signed [8:0] w_ax_s, w_ay_s;
  logic          w_ax_pos, w_ax_neg, w_ay_pos, w_ay_neg;
  dir_t          w_dir_h, w_dir_v;

  assign w_action = frame_tick && (r_div == DIV_LAST);
  assign w_ax_s   = {r_ax[7], r_ax};
  assign w_ay_s   = {r_ay[7], r_ay};
  assign w_ax_pos = w_ax_s > DZ_POS;
  assign w_ax_neg = w_ax_s < DZ_NEG;
  assign w_ay_pos = w_ay_s > DZ_POS;
  assign w_ay_neg = w_ay_s < DZ_NEG;
  assign w_acc_any = w_ax_pos | w_ax_neg | w_ay_pos | w_ay_neg;

  // hold is deliberately taken live at arbitration, everything else from the samples
  always_comb begin
    w_btn_ok = 1'b0;
    w_acc_ok = 1'b0;
    case (r_mode)
      MODE_BTN:    w_btn_ok = 1'b1;
      MODE_ACCEL:  w_acc_ok = 1'b1;
      MODE_SHARED: begin w_btn_ok = 1'b1; w_acc_ok = 1'b1; end
      default:     ;
    endcase
    w_req_b = w_btn_ok && !hold && (|r_btn);
    w_req_a = w_acc_ok && !hold && w_acc_any;
    w_gnt   = 2'b00;
    if (w_req_b && w_req_a) w_gnt = (r_rr_last == 2'b01) ? 2'b10 : 2'b01;
    else if (w_req_b)       w_gnt = 2'b01;
    else if (w_req_a)       w_gnt = 2'b10;
  end

  always_comb begin
    w_dir_h = DIR_NONE;
    w_dir_v = DIR_NONE;
    if (r_grant[0]) begin
      if (r_btn[1]) w_dir_h = DIR_DEC; else if (r_btn[0]) w_dir_h = DIR_INC;
      if (r_btn[3]) w_dir_v = DIR_DEC; else if (r_btn[2]) w_dir_v = DIR_INC;
    end else if (r_grant[1]) begin
      if (w_ay_pos) w_dir_h = DIR_DEC; else if (w_ay_neg) w_dir_h = DIR_INC;
      if (w_ax_neg) w_dir_v = DIR_DEC; else if (w_ax_pos) w_dir_v = DIR_INC;
    end
  end

  axis_step #(.SPEED(SPEED)) u_step_h (
    .i_coord(r_h), .i_dir(w_dir_h), .i_limit(H_MAX), .o_coord(w_h_next)
  );

  axis_step #(.SPEED(SPEED)) u_step_v (
    .i_coord(r_v), .i_dir(w_dir_v), .i_limit(V_MAX), .o_coord(w_v_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_action) w_state_nxt = S_ARB;
      S_ARB:    w_state_nxt = (|w_gnt) ? S_STEP_H : S_DONE;
      S_STEP_H: w_state_nxt = S_STEP_V;
      S_STEP_V: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_btn       <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_mode      <= MODE_FROZEN;
      r_grant     <= '0;
      r_rr_last   <= '0;
      r_h         <= H_RST;
      r_v         <= V_RST;
      r_move_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_move_done <= 1'b0;
      if (frame_tick) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
        if (r_state != S_IDLE) r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (w_action) begin
          r_btn  <= {btn_u, btn_d, btn_l, btn_r};
          r_ax   <= accel_x;
          r_ay   <= accel_y;
          r_mode <= mode_t'(mode);
        end
        S_ARB: begin
          r_grant <= w_gnt;
          if (|w_gnt) r_rr_last <= w_gnt;
        end
        S_STEP_H: r_h <= w_h_next;
        S_STEP_V: begin
          r_v         <= w_v_next;
          r_move_done <= |r_grant;
        end
        S_DONE:  r_grant <= '0;
        default: ;
      endcase
    end
  end

  assign obj_h     = r_h;
  assign obj_v     = r_v;
  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign move_done = r_move_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_game_move_sched.sv
// Bench for game_move_sched: directed table, cycle-exact latency/overrun/reset sequences,
// edge saturation, and randomized actions against a transaction-level model.
module tb_game_move_sched;

  localparam int FPA  = 2;
  localparam int DZ   = 2;
  localparam int SPD  = 1;
  localparam int HMAX = 791;
  localparam int VMAX = 579;

  logic       pixel_clk = 1'b0;
  logic       rst, frame_tick, hold;
  logic [1:0] mode;
  logic       btn_u, btn_d, btn_l, btn_r;
  logic [7:0] accel_x, accel_y;
  logic [9:0] obj_h, obj_v;
  logic [1:0] grant;
  logic       busy, move_done, overrun;

  game_move_sched #(
    .OBJ_W(8), .OBJ_H(20), .FRAMES_PER_ACTION(FPA), .SPEED(SPD), .ACCEL_DEADZONE(DZ)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .frame_tick(frame_tick), .hold(hold), .mode(mode),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .accel_x(accel_x), .accel_y(accel_y),
    .obj_h(obj_h), .obj_v(obj_v), .grant(grant), .busy(busy),
    .move_done(move_done), .overrun(overrun)
  );

  always #14 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [1:0] m;
    logic       hd;
    logic [3:0] b;   // {u, d, l, r}
    logic [7:0] ax, ay;
    logic [1:0] g;
    int         dh, dv, dn;
  } vec_t;

  vec_t tbl [16];
  int n_tests = 0;
  int n_fail  = 0;
  int mh, mv, mrr, mdiv;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [1:0] m, input logic hd, input logic [3:0] b,
                        input logic [7:0] ax, input logic [7:0] ay);
    mode = m; hold = hd; {btn_u, btn_d, btn_l, btn_r} = b; accel_x = ax; accel_y = ay;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0;
    set_in(2'b00, 1'b0, 4'b0000, 8'h00, 8'h00);
    repeat (3) @(negedge pixel_clk);
    rst = 1'b0;
    mh = 399; mv = 299; mrr = 0; mdiv = 0;
    @(negedge pixel_clk);
  endtask

  task automatic pulse_tick(output bit was_action);
    was_action = (mdiv == FPA - 1);
    mdiv = (mdiv + 1) % FPA;
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
  endtask

  function automatic logic [7:0] rand_acc();
    case ($urandom_range(0, 6))
      0:       return 8'h00;
      1:       return 8'h02;
      2:       return 8'hFE;
      3:       return 8'h03;
      4:       return 8'hFD;
      5:       return ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // Returns with the action sequence finished; inputs optionally scrambled right after sampling.
  task automatic do_action(input logic [1:0] m, input logic hd, input logic [3:0] b,
                           input logic [7:0] ax, input logic [7:0] ay, input bit scramble,
                           output logic [1:0] g_seen, output int dones);
    bit act = 1'b0;
    set_in(m, hd, b, ax, ay);
    for (int k = 0; k < FPA && !act; k++) pulse_tick(act);
    g_seen = 2'b00; dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0 && scramble) set_in(2'($urandom), hd, 4'($urandom), rand_acc(), rand_acc());
      g_seen |= grant;
      dones += int'(move_done);
      @(negedge pixel_clk);
    end
  endtask

  function automatic int fit(input int x, input int mx);
`ifdef GAME_MOVE_WRAP_EN
    if (x < 0) return mx;
    if (x > mx) return 0;
`else
    if (x < 0) return 0;
    if (x > mx) return mx;
`endif
    return x;
  endfunction

  // Reference: one action decided from the rules, positions/rr kept as plain integers.
  function automatic void model(input logic [1:0] m, input logic hd, input logic [3:0] b,
                                input logic [7:0] ax, input logic [7:0] ay, output logic [1:0] g);
    int sx, sy, dh, dv;
    bit br, ar;
    sx = int'($signed(ax));
    sy = int'($signed(ay));
    br = (b != 4'b0000) && (m == 2'b11 || m == 2'b01) && !hd;
    ar = (sx > DZ || sx < -DZ || sy > DZ || sy < -DZ) && (m == 2'b10 || m == 2'b01) && !hd;
    if (br && ar) g = (mrr == 1) ? 2'b10 : 2'b01;
    else if (br)  g = 2'b01;
    else if (ar)  g = 2'b10;
    else          g = 2'b00;
    dh = 0; dv = 0;
    if (g == 2'b01) begin
      if (b[1]) dh = -1; else if (b[0]) dh = 1;
      if (b[3]) dv = -1; else if (b[2]) dv = 1;
      mrr = 1;
    end else if (g == 2'b10) begin
      if (sy > DZ) dh = -1; else if (sy < -DZ) dh = 1;
      if (sx < -DZ) dv = -1; else if (sx > DZ) dv = 1;
      mrr = 2;
    end
    mh = fit(mh + dh * SPD, HMAX);
    mv = fit(mv + dv * SPD, VMAX);
  endfunction

  initial begin
    logic [1:0] gs, ge;
    int dn, th, tv;
    bit act;
    int e_busy [5] = '{1, 1, 1, 1, 0};
    int e_h    [5] = '{399, 399, 400, 400, 400};
    int e_v    [5] = '{299, 299, 299, 300, 300};
    int e_done [5] = '{0, 0, 0, 1, 0};
    int e_gnt  [5] = '{0, 1, 1, 1, 0};

    tbl[0]  = '{2'b11, 1'b0, 4'b0001, 8'h00, 8'h00, 2'b01,  1,  0, 1};
    tbl[1]  = '{2'b11, 1'b0, 4'b0001, 8'h00, 8'h00, 2'b01,  1,  0, 1};
    tbl[2]  = '{2'b10, 1'b0, 4'b0000, 8'h01, 8'hF6, 2'b10,  1,  0, 1};
    tbl[3]  = '{2'b10, 1'b0, 4'b0000, 8'h01, 8'hF6, 2'b10,  1,  0, 1};
    tbl[4]  = '{2'b01, 1'b0, 4'b1000, 8'h00, 8'h0A, 2'b01,  0, -1, 1};
    tbl[5]  = '{2'b01, 1'b0, 4'b1000, 8'h00, 8'h0A, 2'b10, -1,  0, 1};
    tbl[6]  = '{2'b01, 1'b0, 4'b1000, 8'h00, 8'h0A, 2'b01,  0, -1, 1};
    tbl[7]  = '{2'b01, 1'b0, 4'b1000, 8'h00, 8'h0A, 2'b10, -1,  0, 1};
    tbl[8]  = '{2'b11, 1'b1, 4'b0010, 8'h00, 8'h00, 2'b00,  0,  0, 0};
    tbl[9]  = '{2'b00, 1'b0, 4'b0010, 8'h00, 8'h00, 2'b00,  0,  0, 0};
    tbl[10] = '{2'b11, 1'b0, 4'b1111, 8'h00, 8'h00, 2'b01, -1, -1, 1};
    tbl[11] = '{2'b10, 1'b0, 4'b0000, 8'h03, 8'h02, 2'b10,  0,  1, 1};
    tbl[12] = '{2'b10, 1'b0, 4'b0000, 8'hFE, 8'h02, 2'b00,  0,  0, 0};
    tbl[13] = '{2'b11, 1'b0, 4'b0000, 8'h80, 8'h7F, 2'b00,  0,  0, 0};
    tbl[14] = '{2'b10, 1'b0, 4'b0000, 8'h80, 8'h7F, 2'b10, -1, -1, 1};
    tbl[15] = '{2'b01, 1'b0, 4'b0000, 8'h00, 8'hFD, 2'b10,  1,  0, 1};

    do_reset();
    chk("rst_obj_h", int'(obj_h), 399);
    chk("rst_obj_v", int'(obj_v), 299);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_move_done", int'(move_done), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Cycle-exact latency of one button action moving right and down.
    set_in(2'b11, 1'b0, 4'b0101, 8'h00, 8'h00);
    pulse_tick(act);
    chk("lat_first_tick_idle", int'(busy), 0);
    pulse_tick(act);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("lat_busy_t%0d", s + 1), int'(busy), e_busy[s]);
      chk($sformatf("lat_obj_h_t%0d", s + 1), int'(obj_h), e_h[s]);
      chk($sformatf("lat_obj_v_t%0d", s + 1), int'(obj_v), e_v[s]);
      chk($sformatf("lat_done_t%0d", s + 1), int'(move_done), e_done[s]);
      chk($sformatf("lat_grant_t%0d", s + 1), int'(grant), e_gnt[s]);
      @(negedge pixel_clk);
    end

    do_reset();
    th = 399; tv = 299;
    for (int i = 0; i < 16; i++) begin
      do_action(tbl[i].m, tbl[i].hd, tbl[i].b, tbl[i].ax, tbl[i].ay, 1'b0, gs, dn);
      th += tbl[i].dh; tv += tbl[i].dv;
      chk($sformatf("vec%0d_grant", i), int'(gs), int'(tbl[i].g));
      chk($sformatf("vec%0d_done", i), dn, tbl[i].dn);
      chk($sformatf("vec%0d_obj_h", i), int'(obj_h), th);
      chk($sformatf("vec%0d_obj_v", i), int'(obj_v), tv);
      chk($sformatf("vec%0d_idle", i), int'(busy), 0);
    end

    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic [1:0] rm;
      logic       rh;
      logic [3:0] rb;
      logic [7:0] rx, ry;
      rm = 2'($urandom);
      rh = ($urandom_range(0, 7) == 0);
      rb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
      rx = rand_acc();
      ry = rand_acc();
      model(rm, rh, rb, rx, ry, ge);
      do_action(rm, rh, rb, rx, ry, 1'b1, gs, dn);
      chk($sformatf("rnd%0d_grant", i), int'(gs), int'(ge));
      chk($sformatf("rnd%0d_done", i), dn, (ge != 2'b00) ? 1 : 0);
      chk($sformatf("rnd%0d_obj_h", i), int'(obj_h), mh);
      chk($sformatf("rnd%0d_obj_v", i), int'(obj_v), mv);
    end

    // Walk to the right and top edges, then push once more.
    do_reset();
    for (int i = 0; i < 392; i++) do_action(2'b11, 1'b0, 4'b0001, 8'h00, 8'h00, 1'b0, gs, dn);
    chk("edge_h_reach_max", int'(obj_h), 791);
    do_action(2'b11, 1'b0, 4'b0001, 8'h00, 8'h00, 1'b0, gs, dn);
`ifdef GAME_MOVE_WRAP_EN
    chk("edge_h_past_max", int'(obj_h), 0);
`else
    chk("edge_h_past_max", int'(obj_h), 791);
`endif
    chk("edge_h_done", dn, 1);
    for (int i = 0; i < 299; i++) do_action(2'b11, 1'b0, 4'b1000, 8'h00, 8'h00, 1'b0, gs, dn);
    chk("edge_v_reach_zero", int'(obj_v), 0);
    do_action(2'b11, 1'b0, 4'b1000, 8'h00, 8'h00, 1'b0, gs, dn);
`ifdef GAME_MOVE_WRAP_EN
    chk("edge_v_below_zero", int'(obj_v), 579);
`else
    chk("edge_v_below_zero", int'(obj_v), 0);
`endif

    // Tick two cycles into a sequence, then reset in the middle of the next one.
    do_reset();
    set_in(2'b11, 1'b0, 4'b0001, 8'h00, 8'h00);
    pulse_tick(act);
    pulse_tick(act);
    chk("ovr_before", int'(overrun), 0);
    @(negedge pixel_clk) frame_tick = 1'b1;
    mdiv = (mdiv + 1) % FPA;
    @(negedge pixel_clk) frame_tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    repeat (4) @(negedge pixel_clk);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_obj_h", int'(obj_h), 400);
    chk("ovr_idle", int'(busy), 0);
    pulse_tick(act);
    @(negedge pixel_clk);
    chk("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_obj_h", int'(obj_h), 399);
    chk("mid_rst_obj_v", int'(obj_v), 299);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_grant", int'(grant), 0);
    @(negedge pixel_clk);
    rst = 1'b0;
    repeat (3) @(negedge pixel_clk);
    chk("post_rst_obj_h", int'(obj_h), 399);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
